// File: rtl/router_reg_gen.sv
`default_nettype none
// ============================================================================
//  Module      : router_reg_gen
//  Description : Register stage of the 1x3 router. It latches the packet
//                header, forwards header and payload to the output FIFO,
//                parks one word while the FIFO is full, and accumulates a
//                packet check value (XOR parity or MSB-first CRC). It flags
//                a mismatch against the received check word, and a mismatch
//                between the payload count and the header length field.
//  Revision    : 1.0 - initial release
// ============================================================================
module router_reg_gen #(
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 2,
    parameter int                CHECK_MODE = 0,
    parameter logic [DATA_W-1:0] POLY       = DATA_W'(8'h07)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              rst_int_reg,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] dout,
    output logic              parity_done,
    output logic              low_pkt_valid,
    output logic              err,
    output logic              len_err
);

    localparam int c_LEN_W = DATA_W - ADDR_W;

    logic [DATA_W-1:0]  r_hdr;
    logic [DATA_W-1:0]  r_hold;
    logic [DATA_W-1:0]  r_chk;
    logic [DATA_W-1:0]  r_ext_chk;
    logic [c_LEN_W-1:0] r_cnt;
    logic [DATA_W-1:0]  r_dout;
    logic               r_parity_done;
    logic               r_parity_done_q;
    logic               r_low_pkt_valid;
    logic               r_err;
    logic               r_len_err;

    logic               w_hdr_capture;
    logic               w_err_eval;

    // One step of the running check: XOR parity, or a whole-word CRC update
    // (fold the word in, then clock the register DATA_W times).
    function automatic logic [DATA_W-1:0] f_chk(input logic [DATA_W-1:0] c,
                                                 input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] v;
        v = c ^ d;
        if (CHECK_MODE == 1) begin
            for (int i = 0; i < DATA_W; i++) begin
                v = v[DATA_W-1] ? ((v << 1) ^ POLY) : (v << 1);
            end
        end
        return v;
    endfunction

    // A header capture clears the error flags, so it must also suppress an
    // error evaluation landing on the same cycle.
    assign w_hdr_capture = detect_add & pkt_valid;
    assign w_err_eval    = r_parity_done & ~r_parity_done_q & ~w_hdr_capture;

    // Datapath, check accumulation, handshake flags and error evaluation.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_hdr           <= '0;
            r_hold          <= '0;
            r_chk           <= '0;
            r_ext_chk       <= '0;
            r_cnt           <= '0;
            r_dout          <= '0;
            r_parity_done   <= 1'b0;
            r_parity_done_q <= 1'b0;
            r_low_pkt_valid <= 1'b0;
            r_err           <= 1'b0;
            r_len_err       <= 1'b0;
        end else begin
            r_parity_done_q <= r_parity_done;

            if (detect_add) begin
                if (pkt_valid) begin
                    r_hdr         <= data_in;
                    r_chk         <= f_chk('0, data_in);
                    r_cnt         <= '0;
                    r_parity_done <= 1'b0;
                    r_err         <= 1'b0;
                    r_len_err     <= 1'b0;
                end
            end else if (lfd_state) begin
                r_dout <= r_hdr;
            end else if (ld_state) begin
                if (!full_state) begin
                    if (pkt_valid) begin
                        r_chk <= f_chk(r_chk, data_in);
                        if (r_cnt != {c_LEN_W{1'b1}}) begin
                            r_cnt <= r_cnt + c_LEN_W'(1);
                        end
                        if (!fifo_full) begin
                            r_dout <= data_in;
                        end else begin
                            r_hold <= data_in;
                        end
                    end else begin
                        r_ext_chk       <= data_in;
                        r_low_pkt_valid <= 1'b1;
                        if (!fifo_full) begin
                            r_dout        <= data_in;
                            r_parity_done <= 1'b1;
                        end else begin
                            r_hold <= data_in;
                        end
                    end
                end
            end else if (laf_state) begin
                r_dout <= r_hold;
                if (r_low_pkt_valid && !r_parity_done) begin
                    r_parity_done <= 1'b1;
                end
            end

            if (w_err_eval) begin
                r_err     <= (r_chk != r_ext_chk);
                r_len_err <= (r_cnt != r_hdr[DATA_W-1:ADDR_W]);
            end

            // Clearing the check-word flag takes precedence over setting it.
            if (rst_int_reg) begin
                r_low_pkt_valid <= 1'b0;
            end
        end
    end

    assign dout          = r_dout;
    assign parity_done   = r_parity_done;
    assign low_pkt_valid = r_low_pkt_valid;
    assign err           = r_err;
    assign len_err       = r_len_err;

endmodule
`default_nettype wire
